// File: rtl/branch_predictor_tournament_param.sv
// Tournament predictor: per-PC local history + gshare/global counters, arbitrated by a chooser table.
// Latency: prediction is combinational from i_req_pc; feedback updates land on the accepting edge.
// Backpressure: none; one feedback per cycle, ignored while the post-reset table sweep runs (o_ready=0).
module branch_predictor_tournament_param #(
  parameter int ADDR_WIDTH       = 32,
  parameter int LHT_IDX_BITS     = 10,
  parameter int LHIST_BITS       = 10,
  parameter int GHIST_BITS       = 12,
  parameter int CHOOSER_IDX_BITS = 12,
  parameter int CTR_BITS         = 2,
  parameter int GSHARE           = 1,
  parameter int STAT_BITS        = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  input  logic [ADDR_WIDTH-1:0] i_req_target,
  output logic                  o_req_prediction,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic                  i_fb_prediction,
  input  logic                  i_fb_outcome,
  output logic                  o_ready,
  output logic [STAT_BITS-1:0]  o_total,
  output logic [STAT_BITS-1:0]  o_correct
);

  localparam int MAX_A      = (LHT_IDX_BITS > LHIST_BITS) ? LHT_IDX_BITS : LHIST_BITS;
  localparam int MAX_B      = (GHIST_BITS > CHOOSER_IDX_BITS) ? GHIST_BITS : CHOOSER_IDX_BITS;
  localparam int SWEEP_BITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [SWEEP_BITS-1:0]   sweep_q;
  logic [GHIST_BITS-1:0]   ghr;

  logic [LHIST_BITS-1:0] lht     [2**LHT_IDX_BITS];
  logic [CTR_BITS-1:0]   lctr    [2**LHIST_BITS];
  logic [CTR_BITS-1:0]   gctr    [2**GHIST_BITS];
  logic [CTR_BITS-1:0]   chooser [2**CHOOSER_IDX_BITS];

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  // Request-side lookup
  logic [LHT_IDX_BITS-1:0]     rq_lidx;
  logic [LHIST_BITS-1:0]       rq_lh;
  logic [GHIST_BITS-1:0]       rq_gidx;
  logic [CHOOSER_IDX_BITS-1:0] rq_cidx;
  logic                        rq_lp, rq_gp, rq_sel;

  assign rq_lidx = i_req_pc[LHT_IDX_BITS+1:2];
  assign rq_lh   = lht[rq_lidx];
  assign rq_gidx = (GSHARE != 0) ? (ghr ^ i_req_pc[GHIST_BITS+1:2]) : ghr;
  assign rq_cidx = ghr[CHOOSER_IDX_BITS-1:0] ^ i_req_pc[CHOOSER_IDX_BITS+1:2];
  assign rq_lp   = lctr[rq_lh][CTR_BITS-1];
  assign rq_gp   = gctr[rq_gidx][CTR_BITS-1];
  assign rq_sel  = chooser[rq_cidx][CTR_BITS-1];

  assign o_req_prediction = (state_q == ST_RUN) && (rq_sel ? rq_gp : rq_lp);
  assign o_ready          = (state_q == ST_RUN);

  // Feedback-side lookup, all from pre-edge state
  logic [LHT_IDX_BITS-1:0]     fb_lidx;
  logic [LHIST_BITS-1:0]       fb_lh;
  logic [GHIST_BITS-1:0]       fb_gidx;
  logic [CHOOSER_IDX_BITS-1:0] fb_cidx;
  logic                        fb_lp, fb_gp, fb_en;

  assign fb_lidx = i_fb_pc[LHT_IDX_BITS+1:2];
  assign fb_lh   = lht[fb_lidx];
  assign fb_gidx = (GSHARE != 0) ? (ghr ^ i_fb_pc[GHIST_BITS+1:2]) : ghr;
  assign fb_cidx = ghr[CHOOSER_IDX_BITS-1:0] ^ i_fb_pc[CHOOSER_IDX_BITS+1:2];
  assign fb_lp   = lctr[fb_lh][CTR_BITS-1];
  assign fb_gp   = gctr[fb_gidx][CTR_BITS-1];
  assign fb_en   = (state_q == ST_RUN) && i_fb_valid;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && sweep_q == {SWEEP_BITS{1'b1}}) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      ghr       <= '0;
      o_total   <= '0;
      o_correct <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) sweep_q <= sweep_q + SWEEP_BITS'(1);
      if (fb_en) begin
        ghr     <= {ghr[GHIST_BITS-2:0], i_fb_outcome};
        o_total <= o_total + STAT_BITS'(1);
        if (i_fb_prediction == i_fb_outcome) o_correct <= o_correct + STAT_BITS'(1);
      end
    end
  end

  // Tables have no reset of their own; the INIT sweep writes each entry once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        if (int'(sweep_q) < (1 << LHT_IDX_BITS))     lht[sweep_q[LHT_IDX_BITS-1:0]]         <= '0;
        if (int'(sweep_q) < (1 << LHIST_BITS))       lctr[sweep_q[LHIST_BITS-1:0]]          <= CTR_WEAK;
        if (int'(sweep_q) < (1 << GHIST_BITS))       gctr[sweep_q[GHIST_BITS-1:0]]          <= CTR_WEAK;
        if (int'(sweep_q) < (1 << CHOOSER_IDX_BITS)) chooser[sweep_q[CHOOSER_IDX_BITS-1:0]] <= CTR_WEAK;
      end else if (fb_en) begin
        lctr[fb_lh]   <= ctr_step(lctr[fb_lh], i_fb_outcome);
        gctr[fb_gidx] <= ctr_step(gctr[fb_gidx], i_fb_outcome);
        lht[fb_lidx]  <= {fb_lh[LHIST_BITS-2:0], i_fb_outcome};
        if (fb_lp == i_fb_outcome && fb_gp != i_fb_outcome)
          chooser[fb_cidx] <= ctr_step(chooser[fb_cidx], 1'b0);
        else if (fb_gp == i_fb_outcome && fb_lp != i_fb_outcome)
          chooser[fb_cidx] <= ctr_step(chooser[fb_cidx], 1'b1);
      end
    end
  end

  // Port-compatibility inputs and the discarded PC bits.
  logic unused_inputs;
  assign unused_inputs = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc};

endmodule

// File: tb/tb_branch_predictor_tournament_param.sv
// Directed bench for branch_predictor_tournament_param with default parameters (sweep length 4096).
module tb_branch_predictor_tournament_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic [31:0] i_req_pc;
  logic [31:0] i_req_target;
  logic        o_req_prediction;
  logic        i_fb_valid;
  logic [31:0] i_fb_pc;
  logic        i_fb_prediction;
  logic        i_fb_outcome;
  logic        o_ready;
  logic [19:0] o_total;
  logic [19:0] o_correct;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_predictor_tournament_param dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (i_req_valid),
    .i_req_pc         (i_req_pc),
    .i_req_target     (i_req_target),
    .o_req_prediction (o_req_prediction),
    .i_fb_valid       (i_fb_valid),
    .i_fb_pc          (i_fb_pc),
    .i_fb_prediction  (i_fb_prediction),
    .i_fb_outcome     (i_fb_outcome),
    .o_ready          (o_ready),
    .o_total          (o_total),
    .o_correct        (o_correct)
  );

  task automatic do_fb(input logic [31:0] pc, input logic pred, input logic outc);
    i_fb_valid = 1'b1;
    i_fb_pc = pc;
    i_fb_prediction = pred;
    i_fb_outcome = outc;
    @(posedge clk); #1;
    i_fb_valid = 1'b0;
  endtask

  // Counts cycles with o_ready low; feedback is dropped before the first RUN edge.
  task automatic wait_sweep(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (o_ready === 1'b1 || n >= 5000) break;
      n++;
      @(posedge clk); #1;
    end
    i_fb_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_req_pc = 32'h100;
    #1;
    n_total++;
    if (o_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", o_ready); else n_pass++;
    n_total++;
    if (o_total !== 20'd0) $display("FAIL reset_total: got %0d expected 0", o_total); else n_pass++;
    n_total++;
    if (o_req_prediction !== 1'b0) $display("FAIL reset_pred: got %b expected 0", o_req_prediction); else n_pass++;
  endtask

  task automatic test_sweep();
    int n;
    i_fb_valid = 1'b1;
    i_fb_pc = 32'h100;
    i_fb_prediction = 1'b1;
    i_fb_outcome = 1'b1;
    rst = 1'b0;
    wait_sweep(n);
    n_total++;
    if (n !== 4096) $display("FAIL sweep_len: got %0d expected 4096", n); else n_pass++;
    n_total++;
    if (o_total !== 20'd0) $display("FAIL init_fb_ignored: got %0d expected 0", o_total); else n_pass++;
  endtask

  task automatic test_post_init();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h100; pcs[2] = 32'hABC;
    for (int i = 0; i < 3; i++) begin
      i_req_pc = pcs[i];
      #1;
      n_total++;
      if (o_req_prediction !== 1'b0)
        $display("FAIL post_init_pred pc=%h: got %b expected 0", pcs[i], o_req_prediction);
      else n_pass++;
    end
    n_total++;
    if (o_total !== 20'd0) $display("FAIL post_init_total: got %0d expected 0", o_total); else n_pass++;
    n_total++;
    if (o_correct !== 20'd0) $display("FAIL post_init_correct: got %0d expected 0", o_correct); else n_pass++;
  endtask

  // Ten TAKENs walk the local history 0->0x3ff touching a fresh counter each time.
  task automatic test_local();
    for (int i = 0; i < 10; i++) do_fb(32'h100, 1'b0, 1'b1);
    i_req_pc = 32'h100;
    #1;
    n_total++;
    if (o_req_prediction !== 1'b0) $display("FAIL local_after10: got %b expected 0", o_req_prediction); else n_pass++;
    i_fb_valid = 1'b1;
    i_fb_pc = 32'h100;
    i_fb_prediction = 1'b0;
    i_fb_outcome = 1'b1;
    #1;
    n_total++;
    if (o_req_prediction !== 1'b0) $display("FAIL same_cycle_no_bypass: got %b expected 0", o_req_prediction); else n_pass++;
    @(posedge clk); #1;
    i_fb_valid = 1'b0;
    #1;
    n_total++;
    if (o_req_prediction !== 1'b1) $display("FAIL local_after11: got %b expected 1", o_req_prediction); else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 40; i++) do_fb(32'h100, 1'b1, 1'b1);
    i_req_pc = 32'h100;
    #1;
    n_total++;
    if (o_req_prediction !== 1'b1) $display("FAIL sat_pred: got %b expected 1", o_req_prediction); else n_pass++;
    n_total++;
    if (o_total !== 20'd51) $display("FAIL sat_total: got %0d expected 51", o_total); else n_pass++;
    n_total++;
    if (o_correct !== 20'd40) $display("FAIL sat_correct: got %0d expected 40", o_correct); else n_pass++;
    // The NOT_TAKEN shifts local history to 0x3fe, an untouched weak counter.
    do_fb(32'h100, 1'b1, 1'b0);
    i_req_pc = 32'h100;
    #1;
    n_total++;
    if (o_req_prediction !== 1'b0) $display("FAIL nt_pred: got %b expected 0", o_req_prediction); else n_pass++;
    n_total++;
    if (o_total !== 20'd52) $display("FAIL nt_total: got %0d expected 52", o_total); else n_pass++;
    n_total++;
    if (o_correct !== 20'd40) $display("FAIL nt_correct: got %0d expected 40", o_correct); else n_pass++;
  endtask

  task automatic test_midrun_reset();
    int n;
    rst = 1'b1;
    i_fb_valid = 1'b1;
    i_fb_pc = 32'h100;
    i_fb_prediction = 1'b1;
    i_fb_outcome = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_fb_valid = 1'b0;
    n_total++;
    if (o_ready !== 1'b0) $display("FAIL midrst_ready: got %b expected 0", o_ready); else n_pass++;
    n_total++;
    if (o_total !== 20'd0) $display("FAIL midrst_total: got %0d expected 0", o_total); else n_pass++;
    n_total++;
    if (o_correct !== 20'd0) $display("FAIL midrst_correct: got %0d expected 0", o_correct); else n_pass++;
    wait_sweep(n);
    n_total++;
    if (n !== 4096) $display("FAIL midrst_sweep_len: got %0d expected 4096", n); else n_pass++;
    i_req_pc = 32'h100;
    #1;
    n_total++;
    if (o_req_prediction !== 1'b0) $display("FAIL midrst_pred: got %b expected 0", o_req_prediction); else n_pass++;
  endtask

  // 0x210 then 0x200 share outcome r (21 TAKEN, 1 NOT_TAKEN). Local history is all ones before
  // the NOT_TAKEN so local misses it, while GHR=0xffe singles it out for the global counter.
  task automatic test_chooser();
    logic r;
    for (int i = 0; i < 220; i++) begin
      r = (i % 22) != 21;
      if (i == 219) begin
        i_req_pc = 32'h200;
        #1;
        n_total++;
        if (o_req_prediction !== 1'b1) $display("FAIL chooser_local_ctx: got %b expected 1", o_req_prediction); else n_pass++;
      end
      do_fb(32'h210, 1'b1, r);
      if (i == 219) begin
        i_req_pc = 32'h200;
        #1;
        n_total++;
        if (o_req_prediction !== 1'b0) $display("FAIL chooser_global_ctx: got %b expected 0", o_req_prediction); else n_pass++;
      end
      do_fb(32'h200, 1'b1, r);
    end
    n_total++;
    if (o_total !== 20'd440) $display("FAIL chooser_total: got %0d expected 440", o_total); else n_pass++;
    n_total++;
    if (o_correct !== 20'd420) $display("FAIL chooser_correct: got %0d expected 420", o_correct); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b1;
    i_req_pc = '0;
    i_req_target = '0;
    i_fb_valid = 1'b0;
    i_fb_pc = '0;
    i_fb_prediction = 1'b0;
    i_fb_outcome = 1'b0;
    test_reset();
    test_sweep();
    test_post_init();
    test_local();
    test_saturation();
    test_midrun_reset();
    test_chooser();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
